// File: rtl/cu_pkg.sv
// Shared opcode, state and ALU-select encodings plus the control-word payload for control_unit.
package cu_pkg;

    localparam int unsigned IR_W    = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned RA_W    = 4;

    localparam logic [OPC_W-1:0] OP_NOOP  = 4'd0;
    localparam logic [OPC_W-1:0] OP_STORE = 4'd1;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd2;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'd3;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'd4;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'd5;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

    // Registered datapath controls that depend on the state
    typedef struct packed {
        logic             d_wr;
        logic             rf_s;
        logic             rf_w_en;
        logic [RA_W-1:0]  ra;
        logic [RA_W-1:0]  rb;
        logic [ALU_W-1:0] alu;
        logic             halted;
    } ctrl_t;

    function automatic logic [OPC_W-1:0] opcode(input logic [IR_W-1:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// ROM fetch, datapath control and observation bundle between control_unit and its neighbours.
interface control_unit_if #(parameter int unsigned PC_W = 5);
    logic [15:0]     Instr_In;
    logic [PC_W-1:0] PC_Out;
    logic [15:0]     IR_Out;
    logic [3:0]      StateO;
    logic [7:0]      D_Addr;
    logic            D_Wr;
    logic            RF_s;
    logic [3:0]      RF_W_Addr;
    logic            RF_W_En;
    logic [3:0]      RF_Ra_Addr;
    logic [3:0]      RF_Rb_Addr;
    logic [2:0]      ALU_s0;
    logic            Halted;
    logic            Illegal;

    modport master (
        input  Instr_In,
        output PC_Out, IR_Out, StateO, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, Halted, Illegal
    );

    modport slave (
        output Instr_In,
        input  PC_Out, IR_Out, StateO, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, Halted, Illegal
    );
endinterface

// File: rtl/program_counter.sv
// PC_W-bit program counter: synchronous clear has priority over increment; wraps silently.
module program_counter #(
    parameter int unsigned PC_W = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: PC, IR and Moore datapath controls.
// Optional: define CU_ILLEGAL_TRAP_EN to trap opcodes 6-15 into HALT with Illegal set.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned PC_W = 5
) (
    input  logic           Clk,
    input  logic           Reset,
    control_unit_if.master bus
);

    state_t          state, state_nxt;
    logic [IR_W-1:0] ir, ir_nxt;
    ctrl_t           ctrl, ctrl_nxt;
    logic            illegal, illegal_nxt;
    logic [PC_W-1:0] pc;
    logic            pc_clr, pc_inc;

    assign pc_clr = Reset || (state == ST_INIT);
    assign pc_inc = (state == ST_FETCH);

    program_counter #(.PC_W(PC_W)) u_pc (
        .clk (Clk),
        .clr (pc_clr),
        .inc (pc_inc),
        .pc  (pc)
    );

    // State register; controls are registered from the next state so they stay Moore
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_INIT;
            ir      <= '0;
            ctrl    <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            ir      <= ir_nxt;
            ctrl    <= ctrl_nxt;
            illegal <= illegal_nxt;
        end
    end

    // Next-state and IR capture
    always_comb begin
        state_nxt   = state;
        illegal_nxt = illegal;
        ir_nxt      = (state == ST_FETCH) ? bus.Instr_In : ir;
        unique case (state)
            ST_INIT:   state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                unique case (opcode(ir))
                    OP_NOOP:  state_nxt = ST_NOOP;
                    OP_STORE: state_nxt = ST_STORE;
                    OP_LOAD:  state_nxt = ST_LOAD_A;
                    OP_ADD:   state_nxt = ST_ADD;
                    OP_SUB:   state_nxt = ST_SUB;
                    OP_HALT:  state_nxt = ST_HALT;
                    default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                        state_nxt   = ST_HALT;
                        illegal_nxt = 1'b1;
`else
                        state_nxt   = ST_NOOP;
`endif
                    end
                endcase
            end
            ST_LOAD_A: state_nxt = ST_LOAD_B;
            ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB: state_nxt = ST_FETCH;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_INIT;
        endcase
    end

    // Control decode for the state being entered
    always_comb begin
        ctrl_nxt = '0;
        unique case (state_nxt)
            ST_LOAD_A: ctrl_nxt.rf_s = 1'b1;
            ST_LOAD_B: begin
                ctrl_nxt.rf_s    = 1'b1;
                ctrl_nxt.rf_w_en = 1'b1;
            end
            ST_STORE: begin
                ctrl_nxt.ra   = ir_nxt[3:0];
                ctrl_nxt.d_wr = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                ctrl_nxt.ra      = ir_nxt[11:8];
                ctrl_nxt.rb      = ir_nxt[7:4];
                ctrl_nxt.alu     = (state_nxt == ST_ADD) ? ALU_ADD : ALU_SUB;
                ctrl_nxt.rf_w_en = 1'b1;
            end
            ST_HALT:   ctrl_nxt.halted = 1'b1;
            default:   ctrl_nxt = '0;
        endcase
    end

    assign bus.PC_Out     = pc;
    assign bus.IR_Out     = ir;
    assign bus.StateO     = state;
    assign bus.D_Addr     = ir[11:4];
    assign bus.RF_W_Addr  = ir[3:0];
    assign bus.D_Wr       = ctrl.d_wr;
    assign bus.RF_s       = ctrl.rf_s;
    assign bus.RF_W_En    = ctrl.rf_w_en;
    assign bus.RF_Ra_Addr = ctrl.ra;
    assign bus.RF_Rb_Addr = ctrl.rb;
    assign bus.ALU_s0     = ctrl.alu;
    assign bus.Halted     = ctrl.halted;
    assign bus.Illegal    = illegal;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed program checks plus random programs against an instruction-level trace model.
module tb_control_unit;

    logic Clk;
    logic Reset;
    logic [15:0] rom [32];

    int n_checks;
    int n_errors;

    typedef struct {
        int          st;
        int          pc;
        logic [15:0] ir;
        logic [27:0] ctrl;
    } rec_t;

    rec_t exp_q[$];

    control_unit_if #(.PC_W(5)) bus ();

    control_unit #(.PC_W(5)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.Instr_In = rom[bus.PC_Out];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Expected observable outputs for one cycle, from the state's documented actions
    function automatic rec_t mk(input int st, input int pc, input logic [15:0] ir, input logic ill);
        rec_t r;
        logic dwr = 1'b0, rfs = 1'b0, wen = 1'b0, h = 1'b0;
        logic [3:0] ra = 4'd0, rb = 4'd0;
        logic [2:0] alu = 3'd0;
        case (st)
            4: rfs = 1'b1;
            5: begin rfs = 1'b1; wen = 1'b1; end
            6: begin ra = ir[3:0]; dwr = 1'b1; end
            7: begin ra = ir[11:8]; rb = ir[7:4]; alu = 3'd1; wen = 1'b1; end
            8: begin ra = ir[11:8]; rb = ir[7:4]; alu = 3'd2; wen = 1'b1; end
            9: h = 1'b1;
            default: ;
        endcase
        r.st   = st;
        r.pc   = pc;
        r.ir   = ir;
        r.ctrl = {ir[11:4], dwr, rfs, ir[3:0], wen, ra, rb, alu, h, (st == 9) ? ill : 1'b0};
        return r;
    endfunction

    // Instruction-level program walk producing a per-cycle trace starting at the INIT cycle
    task automatic build_trace(input int ncyc);
        int pc = 0;
        logic [15:0] ir = 16'h0000;
        logic [15:0] w;
        logic halted = 1'b0, ill = 1'b0;
        exp_q.delete();
        exp_q.push_back(mk(0, 0, ir, 1'b0));
        while (exp_q.size() < ncyc) begin
            if (halted) begin
                exp_q.push_back(mk(9, pc, ir, ill));
                continue;
            end
            exp_q.push_back(mk(1, pc, ir, 1'b0));
            w  = rom[pc];
            pc = (pc + 1) % 32;
            ir = w;
            exp_q.push_back(mk(2, pc, ir, 1'b0));
            case (int'(w[15:12]))
                0: exp_q.push_back(mk(3, pc, ir, 1'b0));
                1: exp_q.push_back(mk(6, pc, ir, 1'b0));
                2: begin
                    exp_q.push_back(mk(4, pc, ir, 1'b0));
                    exp_q.push_back(mk(5, pc, ir, 1'b0));
                end
                3: exp_q.push_back(mk(7, pc, ir, 1'b0));
                4: exp_q.push_back(mk(8, pc, ir, 1'b0));
                5: halted = 1'b1;
                default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                    halted = 1'b1;
                    ill    = 1'b1;
`else
                    exp_q.push_back(mk(3, pc, ir, 1'b0));
`endif
                end
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_state", 32'(bus.StateO), 32'd0);
        check("rst_pc", 32'(bus.PC_Out), 32'd0);
        check("rst_ir", 32'(bus.IR_Out), 32'd0);
        check("rst_en", 32'({bus.D_Wr, bus.RF_W_En, bus.RF_s, bus.ALU_s0, bus.Halted, bus.Illegal}), 32'd0);
        Reset = 1'b0;
    endtask

    task automatic run_trace(input int ncyc);
        rec_t e;
        build_trace(ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge Clk);
            e = exp_q[i];
            check($sformatf("state@%0d", i), 32'(bus.StateO), 32'(e.st));
            check($sformatf("pc@%0d", i), 32'(bus.PC_Out), 32'(e.pc));
            check($sformatf("ir@%0d", i), 32'(bus.IR_Out), 32'(e.ir));
            check($sformatf("ctrl@%0d", i),
                  32'({bus.D_Addr, bus.D_Wr, bus.RF_s, bus.RF_W_Addr, bus.RF_W_En,
                       bus.RF_Ra_Addr, bus.RF_Rb_Addr, bus.ALU_s0, bus.Halted, bus.Illegal}),
                  32'(e.ctrl));
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    function automatic logic [15:0] rand_instr();
        int r = int'($urandom_range(0, 99));
        logic [3:0] op;
        if (r < 15)      op = 4'd0;
        else if (r < 35) op = 4'd1;
        else if (r < 55) op = 4'd2;
        else if (r < 75) op = 4'd3;
        else if (r < 93) op = 4'd4;
        else if (r < 96) op = 4'd5;
        else             op = 4'($urandom_range(6, 15));
        return {op, 12'($urandom)};
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset    = 1'b1;
        clear_rom();

        // LOAD sequencing
        rom[0] = 16'h21B0;
        do_reset();
        step(1); check("ld_fetch", 32'(bus.StateO), 32'd1);
        step(1); check("ld_decode", 32'(bus.StateO), 32'd2);
        check("ld_decode_pc", 32'(bus.PC_Out), 32'd1);
        step(1); check("lda_state", 32'(bus.StateO), 32'd4);
        check("lda_rfs", 32'(bus.RF_s), 32'd1);
        check("lda_daddr", 32'(bus.D_Addr), 32'h1B);
        check("lda_wen", 32'(bus.RF_W_En), 32'd0);
        step(1); check("ldb_state", 32'(bus.StateO), 32'd5);
        check("ldb_rfs", 32'(bus.RF_s), 32'd1);
        check("ldb_wen", 32'(bus.RF_W_En), 32'd1);
        check("ldb_waddr", 32'(bus.RF_W_Addr), 32'd0);
        step(1); check("ld_next_state", 32'(bus.StateO), 32'd1);
        check("ld_next_pc", 32'(bus.PC_Out), 32'd1);
        check("ld_next_wen", 32'(bus.RF_W_En), 32'd0);

        // ADD then SUB
        rom[0] = 16'h3122;
        rom[1] = 16'h4122;
        do_reset();
        step(3);
        check("add_ra", 32'(bus.RF_Ra_Addr), 32'd1);
        check("add_rb", 32'(bus.RF_Rb_Addr), 32'd2);
        check("add_alu", 32'(bus.ALU_s0), 32'd1);
        check("add_waddr", 32'(bus.RF_W_Addr), 32'd2);
        check("add_wen", 32'(bus.RF_W_En), 32'd1);
        step(3);
        check("sub_state", 32'(bus.StateO), 32'd8);
        check("sub_alu", 32'(bus.ALU_s0), 32'd2);
        check("sub_wen", 32'(bus.RF_W_En), 32'd1);

        // STORE then HALT, reset applied while halted
        rom[0] = 16'h1803;
        rom[1] = 16'h5000;
        do_reset();
        step(3);
        check("st_state", 32'(bus.StateO), 32'd6);
        check("st_dwr", 32'(bus.D_Wr), 32'd1);
        check("st_daddr", 32'(bus.D_Addr), 32'h80);
        check("st_ra", 32'(bus.RF_Ra_Addr), 32'd3);
        step(3);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt_state@%0d", i), 32'(bus.StateO), 32'd9);
            check($sformatf("halt_flag@%0d", i), 32'(bus.Halted), 32'd1);
            check($sformatf("halt_pc@%0d", i), 32'(bus.PC_Out), 32'd2);
            check($sformatf("halt_ill@%0d", i), 32'(bus.Illegal), 32'd0);
            step(1);
        end

        // PC wrap over 32 NOOPs
        clear_rom();
        do_reset();
        step(97);
        check("wrap_state", 32'(bus.StateO), 32'd1);
        check("wrap_pc", 32'(bus.PC_Out), 32'd0);
        step(1);
        check("wrap_pc_next", 32'(bus.PC_Out), 32'd1);

        // Illegal opcode
        rom[0] = 16'hF000;
        do_reset();
        step(3);
`ifdef CU_ILLEGAL_TRAP_EN
        check("ill_state", 32'(bus.StateO), 32'd9);
        check("ill_flag", 32'(bus.Illegal), 32'd1);
        step(1);
        check("ill_hold", 32'(bus.Illegal), 32'd1);
        check("ill_pc", 32'(bus.PC_Out), 32'd1);
`else
        check("ill_state", 32'(bus.StateO), 32'd3);
        check("ill_flag", 32'(bus.Illegal), 32'd0);
        step(1);
        check("ill_next_state", 32'(bus.StateO), 32'd1);
        check("ill_next_pc", 32'(bus.PC_Out), 32'd1);
`endif

        // Random programs, each reset lands in whatever state the previous run left
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 32; i++) rom[i] = rand_instr();
            do_reset();
            run_trace(int'($urandom_range(30, 160)));
        end
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
